// File: rtl/chaser_input_ctrl_if.sv
// Button inputs and chaser control outputs of chaser_input_ctrl.
// The master side drives the raw buttons; the slave side is the conditioning block.
interface chaser_input_ctrl_if;
    logic       iBTN_DIR;
    logic       iBTN_SPD;
    logic       oDIR;
    logic       oDIR_EVT;
    logic [1:0] oSPEED;
    logic       oSTEP;

    modport master (
        output iBTN_DIR, iBTN_SPD,
        input  oDIR, oDIR_EVT, oSPEED, oSTEP
    );

    modport slave (
        input  iBTN_DIR, iBTN_SPD,
        output oDIR, oDIR_EVT, oSPEED, oSTEP
    );
endinterface

// File: rtl/chaser_input_ctrl.sv
// Button synchronise/debounce/press-detect, direction and speed state,
// and a speed-selected step strobe generator for the LED chaser.
module chaser_input_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned STEP_BASE  = 262144
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    chaser_input_ctrl_if.slave bus
);
    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam int unsigned SW = $clog2(STEP_BASE);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    // Bit 0 carries the direction button, bit 1 the speed button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    press;

    logic          dir_q;
    logic          dir_evt_q;
    logic [1:0]    speed_q;
    logic          step_q;
    logic [SW-1:0] step_cnt;
    logic [SW-1:0] step_max;

    assign raw   = {bus.iBTN_SPD, bus.iBTN_DIR};
    assign press = stable & ~stable_d;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            dir_q     <= 1'b0;
            dir_evt_q <= 1'b0;
            speed_q   <= '0;
        end else begin
            dir_q     <= dir_q ^ press[0];
            dir_evt_q <= press[0];
            if (press[1]) begin
                speed_q <= speed_q + 1'b1;
            end
        end
    end

    always_comb begin
        step_max = SW'(STEP_BASE - 1);
        case (speed_q)
            2'd0: step_max = SW'(STEP_BASE - 1);
            2'd1: step_max = SW'((STEP_BASE >> 1) - 1);
            2'd2: step_max = SW'((STEP_BASE >> 2) - 1);
            2'd3: step_max = SW'((STEP_BASE >> 3) - 1);
            default: step_max = SW'(STEP_BASE - 1);
        endcase
    end

    // A speed press restarts the period and suppresses a coincident strobe.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            step_cnt <= '0;
            step_q   <= 1'b0;
        end else if (press[1]) begin
            step_cnt <= '0;
            step_q   <= 1'b0;
        end else if (step_cnt == step_max) begin
            step_cnt <= '0;
            step_q   <= 1'b1;
        end else begin
            step_cnt <= step_cnt + 1'b1;
            step_q   <= 1'b0;
        end
    end

    assign bus.oDIR     = dir_q;
    assign bus.oDIR_EVT = dir_evt_q;
    assign bus.oSPEED   = speed_q;
    assign bus.oSTEP    = step_q;
endmodule

// File: doc/chaser_input_ctrl.md
# chaser_input_ctrl

Input-conditioning and rate stage feeding the LED chaser. Synchronises and debounces two raw pushbuttons, turns each clean press into a single event, and from those maintains the shift direction and a 2-bit speed setting. A programmable step generator emits a one-cycle `oSTEP` pulse at the selected rate. The chaser shifts once per `oSTEP` in the direction given by `oDIR`, which replaces its free-running divider and raw switch input.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable cycles required to accept a button level (10 ms at 50 MHz); must be ≥ 2.
- `STEP_BASE`, default 262144: step period in cycles at speed 0. Must satisfy `STEP_BASE >> 3` ≥ 2.
- `iCLK`, input, 1: system clock; all state updates on the rising edge.
- `iRST_N`, input, 1: reset, asynchronous, active-low.
- `iBTN_DIR`, input, 1: raw direction pushbutton, active-high, asynchronous and bouncy.
- `iBTN_SPD`, input, 1: raw speed pushbutton, active-high, asynchronous and bouncy.
- `oDIR`, output, 1: shift direction; 0 = left (LSB→MSB), 1 = right.
- `oDIR_EVT`, output, 1: one-cycle pulse, asserted in the same cycle `oDIR` takes its new value.
- `oSPEED`, output, 2: current speed level, 0 (slowest) to 3.
- `oSTEP`, output, 1: one-cycle step strobe for the chaser.

## Operation
- **Reset values** (all asynchronous to `iRST_N`=0): `oDIR`=0, `oDIR_EVT`=0, `oSPEED`=0, `oSTEP`=0. All sync flops, stable states, delayed stable copies and counters are also 0.
- **Per-button synchroniser:** two flops, sync1 then sync2.
- **Per-button debounce:**
  - Debounce counter width is clog2(`DEB_CYCLES`).
  - If sync2 == stable, the counter clears to 0.
  - Otherwise, if counter == `DEB_CYCLES`-1: stable ← sync2 and counter ← 0.
  - Otherwise the counter increments.
  - Any bounce back to the stable level restarts qualification.
- **Press detect:** a registered copy stable_d is kept. A press is stable & ~stable_d.
  - Releases generate nothing.
  - A held button produces exactly one press.
- **Direction:** on a DIR press, `oDIR` ← ~`oDIR` and `oDIR_EVT` = 1 for that cycle only.
- **Speed:** on an SPD press, `oSPEED` ← `oSPEED`+1, wrapping 3→0.
- **Step generator:**
  - Period P = `STEP_BASE` >> `oSPEED`. Counter width is clog2(`STEP_BASE`).
  - The counter runs 0..P-1.
  - When counter == P-1: `oSTEP` ← 1 (registered) and counter ← 0.
  - Otherwise `oSTEP` ← 0 and the counter increments.
- **Speed change priority:** on the cycle an SPD press is applied, the step counter ← 0 and `oSTEP` ← 0, even if the counter was at P-1. The next `oSTEP` follows a full period at the new speed.
- **Simultaneous presses:** DIR and SPD presses in the same cycle are both applied.
- **Buttons are independent:** DIR events never disturb the step counter.
- **Reset mid-operation:** in-progress debounce and step counts are discarded. After release, direction and speed are back to 0.

## Timing
- Let cycle k be the first rising edge at which sync1 samples a new raw level that then stays steady.
  - sync2 follows at k+1.
  - stable updates at k+1+`DEB_CYCLES`.
  - `oDIR`/`oDIR_EVT`/`oSPEED` update at k+2+`DEB_CYCLES`.
- `oSTEP` is high for exactly one cycle. Spacing between consecutive pulses is exactly P cycles at constant speed.
- First `oSTEP` after reset release: P cycles after the first active edge, with the counter at 0 on that edge.
- After a speed change applied at edge m, the next `oSTEP` is high at edge m+P_new.
- `oDIR` is stable between `oDIR_EVT` pulses. The chaser may sample it on any `oSTEP`.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `STEP_BASE`=16.
- **Reset / idle:** hold `iRST_N`=0, then release with buttons low. All outputs are 0. `oSTEP` pulses every 16 cycles, first at the 16th edge after release.
- **Clean DIR press:** raise `iBTN_DIR` and hold it for 20 cycles. `oDIR` goes 0→1 exactly 6 cycles after the sampling edge, with one `oDIR_EVT` pulse. Release causes no change. A second press returns `oDIR` to 0.
- **Bounce rejection:** `iBTN_DIR` pattern 1,1,1,0,1,1,0,1 per cycle, then steady 1. No event until 4 consecutive synced 1s. Then exactly one toggle, and `oDIR_EVT` count = 1.
- **Speed cycling:** four SPD presses. `oSPEED` goes 1, 2, 3, 0. `oSTEP` spacing is 8, 4, 2, 16. Each first pulse after a change lands exactly P_new cycles after the change edge.
- **Collision:** an SPD press is applied on the cycle the step counter = 15 at speed 0. No `oSTEP` that cycle; next `oSTEP` 8 cycles later.
- **Simultaneous presses, then async reset:** press both buttons together. Both `oDIR` and `oSPEED` change on the same edge. Then pulse `iRST_N` low mid-period, between clock edges. Outputs clear immediately without waiting for a clock.
